// File: rtl/dsbc_bus_pkg.sv
// Shared definitions for the DSBC bus bridges: bridge FSM encodings and the
// default downstream byte-address width.
package dsbc_bus_pkg;

  localparam int DSBC_ADDR_W = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    ACK  = 2'd3
  } bridge_state_t;

endpackage

// File: rtl/wb16to8_if.sv
// Signal bundle between a 16-bit Wishbone initiator, the wb16to8 bridge and
// the 8-bit downstream Wishbone target.
interface wb16to8_if
  import dsbc_bus_pkg::*;
#(
  parameter int ADDR_W = DSBC_ADDR_W
);
  // Handshake: the upstream request is taken when i_wb_cyc & i_wb_stb is high
  // in IDLE and completes with a one-cycle o_wb_ack; each downstream access
  // holds o_m_cyc/o_m_stb and its address/data until i_m_ack is sampled high.
  logic              i_wb_cyc;
  logic              i_wb_stb;
  logic              i_wb_we;
  logic [ADDR_W-2:0] i_wb_addr;
  logic [1:0]        i_wb_sel;
  logic [15:0]       i_wb_dat;
  logic [15:0]       o_wb_dat;
  logic              o_wb_ack;
  logic              o_m_cyc;
  logic              o_m_stb;
  logic              o_m_we;
  logic [ADDR_W-1:0] o_m_addr;
  logic [7:0]        o_m_dat;
  logic [7:0]        i_m_dat;
  logic              i_m_ack;

  // Bridge side.
  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_sel, i_wb_dat,
    input  i_m_dat, i_m_ack,
    output o_wb_dat, o_wb_ack,
    output o_m_cyc, o_m_stb, o_m_we, o_m_addr, o_m_dat
  );

  // Environment side: upstream initiator plus downstream target.
  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_sel, i_wb_dat,
    output i_m_dat, i_m_ack,
    input  o_wb_dat, o_wb_ack,
    input  o_m_cyc, o_m_stb, o_m_we, o_m_addr, o_m_dat
  );

endinterface

// File: rtl/wb16to8.sv
// 16-bit to 8-bit Wishbone bridge: splits each upstream word access into up
// to two little-endian byte accesses, low byte first.
module wb16to8
  import dsbc_bus_pkg::*;
#(
  parameter int ADDR_W = DSBC_ADDR_W
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst,
  wb16to8_if.slave      bus,
  output bridge_state_t o_state
);

  bridge_state_t     state;
  logic [ADDR_W-2:0] addr_q;
  logic              we_q;
  logic              sel_hi_q;
  logic [7:0]        dat_hi_q;
  logic [15:0]       rd;

  assign bus.o_wb_dat = rd;
  assign o_state      = state;

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      sel_hi_q     <= 1'b0;
      dat_hi_q     <= 8'h00;
      rd           <= 16'h0000;
      bus.o_wb_ack <= 1'b0;
      bus.o_m_cyc  <= 1'b0;
      bus.o_m_stb  <= 1'b0;
      bus.o_m_we   <= 1'b0;
      bus.o_m_addr <= '0;
      bus.o_m_dat  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          bus.o_wb_ack <= 1'b0;
          if (bus.i_wb_cyc && bus.i_wb_stb) begin
            addr_q   <= bus.i_wb_addr;
            we_q     <= bus.i_wb_we;
            sel_hi_q <= bus.i_wb_sel[1];
            dat_hi_q <= bus.i_wb_dat[15:8];
            rd       <= 16'h0000;
            if (bus.i_wb_sel[0]) begin
              state        <= LO;
              bus.o_m_cyc  <= 1'b1;
              bus.o_m_stb  <= 1'b1;
              bus.o_m_we   <= bus.i_wb_we;
              bus.o_m_addr <= {bus.i_wb_addr, 1'b0};
              bus.o_m_dat  <= bus.i_wb_dat[7:0];
            end else if (bus.i_wb_sel[1]) begin
              state        <= HI;
              bus.o_m_cyc  <= 1'b1;
              bus.o_m_stb  <= 1'b1;
              bus.o_m_we   <= bus.i_wb_we;
              bus.o_m_addr <= {bus.i_wb_addr, 1'b1};
              bus.o_m_dat  <= bus.i_wb_dat[15:8];
            end else begin
              state        <= ACK;
              bus.o_wb_ack <= 1'b1;
            end
          end
        end

        LO: begin
          // Abort wins over a downstream ack arriving in the same cycle.
          if (!bus.i_wb_cyc) begin
            state       <= IDLE;
            bus.o_m_cyc <= 1'b0;
            bus.o_m_stb <= 1'b0;
            bus.o_m_we  <= 1'b0;
          end else if (bus.i_m_ack) begin
            if (!we_q) begin
              rd[7:0] <= bus.i_m_dat;
            end
            if (sel_hi_q) begin
              state        <= HI;
              bus.o_m_addr <= {addr_q, 1'b1};
              bus.o_m_dat  <= dat_hi_q;
            end else begin
              state        <= ACK;
              bus.o_wb_ack <= 1'b1;
              bus.o_m_cyc  <= 1'b0;
              bus.o_m_stb  <= 1'b0;
              bus.o_m_we   <= 1'b0;
            end
          end
        end

        HI: begin
          if (!bus.i_wb_cyc) begin
            state       <= IDLE;
            bus.o_m_cyc <= 1'b0;
            bus.o_m_stb <= 1'b0;
            bus.o_m_we  <= 1'b0;
          end else if (bus.i_m_ack) begin
            if (!we_q) begin
              rd[15:8] <= bus.i_m_dat;
            end
            state        <= ACK;
            bus.o_wb_ack <= 1'b1;
            bus.o_m_cyc  <= 1'b0;
            bus.o_m_stb  <= 1'b0;
            bus.o_m_we   <= 1'b0;
          end
        end

        ACK: begin
          bus.o_wb_ack <= 1'b0;
          state        <= IDLE;
        end

        default: begin
          state        <= IDLE;
          bus.o_wb_ack <= 1'b0;
          bus.o_m_cyc  <= 1'b0;
          bus.o_m_stb  <= 1'b0;
          bus.o_m_we   <= 1'b0;
        end
      endcase
    end
  end

endmodule
